tout_acc_stream: RTL and testbench
==================================

Name: tout_acc_stream

Overview:
- Parametrised successor of the fixed 32-lane reduction tree used by the LN datapath.
- Reduces TOUT signed lanes per beat through a fully registered binary adder tree, with any power-of-two lane count.
- Accumulates the per-beat partial sums across a framed multi-beat packet, delimited by first/last flags.
- Has a per-packet mode: plain sum (LN mean) or sum of squares (LN variance), so one instance serves both LN statistics.

Parameters:
DATA_WIDTH, 16, width of each signed input lane
TOUT, 32, lanes per beat; power of two, 2..128
LOG2_TOUT, 5, log2(TOUT); must match TOUT
BEAT_W, 8, beat-counter width; max beats per packet = 2^BEAT_W
ELEM_W, 2*DATA_WIDTH, lane width after the optional square (derived, not overridable)
ACC_W, ELEM_W+LOG2_TOUT+BEAT_W, accumulator/output width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
i_valid  in  1  input beat valid; no backpressure, every valid beat is accepted
i_first  in  1  first beat of packet; qualified by i_valid
i_last  in  1  last beat of packet; qualified by i_valid
i_sq  in  1  mode, sampled on the first beat: 0 = sum, 1 = sum of squares
i_dat  in  DATA_WIDTH*TOUT  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH], signed
o_valid  out  1  one-cycle pulse; packet result valid
o_dat  out  ACC_W  signed packet result, held until the next o_valid
o_beats  out  BEAT_W+1  number of beats in the reported packet
o_err  out  1  set with o_valid if the packet was malformed or exceeded 2^BEAT_W beats

Behaviour:
- Reset: all pipeline valids, accumulator, beat counter, o_valid, o_dat, o_beats and o_err go to 0 on the first clk edge with rst=1. Reset mid-packet discards all in-flight data; no o_valid is produced for it.
- Stage S0, square/extend, 1 cycle:
  - Each lane is sign-extended to ELEM_W.
  - If the packet mode is 1, each lane is replaced by lane*lane (signed multiply, result >= 0).
  - Mode is latched on the i_first beat and applies to every beat of the packet. On a single-beat packet (i_first=i_last=1), i_sq is used directly.
- Stages S1..S_LOG2_TOUT, tree, 1 cycle each:
  - Stage k adds adjacent pairs from stage k-1, signed, width ELEM_W+k.
  - No truncation, no rounding.
- Stage SA, accumulate, 1 cycle:
  - On a first-flagged beat: acc <= tree_out sign-extended to ACC_W, and beats <= 1.
  - Otherwise: acc <= acc + tree_out, and beats <= beats+1.
  - On a last-flagged beat: o_dat <= new acc value, o_beats <= new beats, o_valid <= 1 for exactly one cycle.
- Latency: i_valid with i_last at edge N gives o_valid at edge N+LOG2_TOUT+2 (7 cycles at default). Throughput is 1 beat per cycle, and gaps in i_valid are allowed anywhere. first/last/valid travel with the data through the valid pipeline.
- Packet-tracking state machine, in SA: states IDLE and ACC.
  - IDLE + first: go to ACC. If last is also set, emit the result and stay in IDLE.
  - ACC + last: emit the result, go to IDLE.
  - IDLE + beat without first: beat is dropped and err_pending is set. err_pending is reported on the next o_valid, then cleared.
  - ACC + first: partial packet discarded, restart from this beat, and o_err=1 on that packet's o_valid.
- Beat overflow:
  - Beat count saturates at 2^BEAT_W.
  - Any further beat still accumulates, possibly wrapping the accumulator modulo 2^ACC_W, and forces o_err=1 on that packet.
  - Within 2^BEAT_W beats the accumulator cannot overflow in either mode.
- Only o_valid, o_dat, o_beats and o_err are outputs; all are registered.

Test Plan:
- Default params, single beat, i_first=i_last=1, i_sq=0, all 32 lanes=1 -> o_valid 7 cycles later, o_dat=32, o_beats=1, o_err=0.
- Single beat, all lanes=-32768, i_sq=0 -> o_dat=-1048576. Same data with i_sq=1 -> o_dat=32*2^30=34359738368, o_err=0.
- 4-beat packet, lanes=1, 2, 3, 4 per beat respectively, i_sq=1 on the first beat only, with two idle cycles between beats 2 and 3 -> single o_valid, o_dat=32*(1+4+9+16)=960, o_beats=4.
- Back-to-back packets on consecutive cycles (P1: 1 beat lanes=-1; P2: 2 beats lanes=5) -> o_valid on two separate cycles, P1 o_dat=-32 and P2 o_dat=320, no cross-contamination.
- Malformed framing: 2 beats then a new i_first before any i_last, packet lanes=2 for 1 beat with last -> o_dat=64, o_beats=1, o_err=1. A lone beat without first is then dropped, and the next packet reports o_err=1.
- rst asserted for 1 cycle while 3 beats are in the tree -> no o_valid for that packet, all outputs 0. A fresh packet afterwards produces the correct result after the normal 7-cycle latency.

Source files
------------

// File: rtl/tout_acc_stream.sv
// tout_acc_stream
//   Reduces TOUT signed lanes per beat through a fully registered binary
//   adder tree, then accumulates the per-beat sums across a packet that is
//   framed by first/last flags. Each packet runs in one of two modes:
//   plain sum (LN mean) or sum of squares (LN variance).
//
//   Pipeline: input register -> S0 (square/extend) -> S1..S_LOG2_TOUT (tree)
//   -> SA (accumulate). A beat whose i_last is sampled at edge N produces
//   o_valid at edge N+LOG2_TOUT+2.
//
// Handshake: there is no ready signal. Every cycle with i_valid=1 delivers
//   one beat and is always accepted. i_first, i_last and i_sq only mean
//   something when i_valid=1. o_valid is a one-cycle pulse. o_dat, o_beats
//   and o_err keep their values until the next pulse.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   i_valid  input beat valid
//   i_first  first beat of a packet
//   i_last   last beat of a packet
//   i_sq     mode, taken from the first beat: 0 = sum, 1 = sum of squares
//   i_dat    TOUT signed lanes; lane k is at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_valid  packet result valid (one-cycle pulse)
//   o_dat    signed packet result
//   o_beats  number of beats in the reported packet (saturates at 2^BEAT_W)
//   o_err    the packet was malformed or had more than 2^BEAT_W beats
module tout_acc_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int TOUT       = 32,
   parameter int LOG2_TOUT  = 5,
   parameter int BEAT_W     = 8,
   localparam int ELEM_W    = 2 * DATA_WIDTH,
   localparam int ACC_W     = ELEM_W + LOG2_TOUT + BEAT_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   input  logic                         i_first,
   input  logic                         i_last,
   input  logic                         i_sq,
   input  logic [DATA_WIDTH*TOUT-1:0]   i_dat,
   output logic                         o_valid,
   output logic signed [ACC_W-1:0]      o_dat,
   output logic [BEAT_W:0]              o_beats,
   output logic                         o_err
);

   localparam logic [0:0]    ST_IDLE  = 1'b0;
   localparam logic [0:0]    ST_ACC   = 1'b1;
   localparam logic [BEAT_W:0] BEAT_MAX = {1'b1, {BEAT_W{1'b0}}};
   localparam logic [BEAT_W:0] BEAT_ONE = {{BEAT_W{1'b0}}, 1'b1};

   // ---------------- input register ----------------
   logic                       in_v, in_f, in_l, in_sq;
   logic [DATA_WIDTH*TOUT-1:0] in_dat;

   always_ff @(posedge clk) begin
      if (rst) in_v <= 1'b0;
      else     in_v <= i_valid;
      in_f   <= i_first;
      in_l   <= i_last;
      in_sq  <= i_sq;
      in_dat <= i_dat;
   end

   // ---------------- S0: square / extend ----------------
   // On the first beat, i_sq is used directly. This covers single-beat
   // packets without waiting one cycle for the latch to update.
   logic sq_mode;
   logic sq_eff;
   logic signed [ELEM_W-1:0] lane_ext [TOUT];
   logic signed [ELEM_W-1:0] s0       [TOUT];

   assign sq_eff = (in_v && in_f) ? in_sq : sq_mode;

   always_comb begin
      for (int k = 0; k < TOUT; k++)
         lane_ext[k] = ELEM_W'($signed(in_dat[k*DATA_WIDTH +: DATA_WIDTH]));
   end

   always_ff @(posedge clk) begin
      if (rst)                 sq_mode <= 1'b0;
      else if (in_v && in_f)   sq_mode <= in_sq;
      for (int k = 0; k < TOUT; k++)
         s0[k] <= sq_eff ? lane_ext[k] * lane_ext[k] : lane_ext[k];
   end

   // Flag pipeline. Index 0 lines up with S0, and index k with tree level k.
   logic [LOG2_TOUT:0] pv, pf, pl;

   always_ff @(posedge clk) begin
      if (rst) pv <= '0;
      else     pv <= {pv[LOG2_TOUT-1:0], in_v};
      pf <= {pf[LOG2_TOUT-1:0], in_f};
      pl <= {pl[LOG2_TOUT-1:0], in_l};
   end

   // ---------------- S1..S_LOG2_TOUT: adder tree ----------------
   // Each level grows by one bit, so no result is ever truncated. The
   // sign-extended unsigned concatenations give the exact signed sum.
   for (genvar k = 1; k <= LOG2_TOUT; k++) begin : lvl
      logic signed [ELEM_W+k-1:0] sum [TOUT>>k];
      if (k == 1) begin : g_first
         always_ff @(posedge clk) begin
            for (int j = 0; j < (TOUT >> 1); j++)
               sum[j] <= {s0[2*j][ELEM_W-1],   s0[2*j]}
                       + {s0[2*j+1][ELEM_W-1], s0[2*j+1]};
         end
      end else begin : g_next
         always_ff @(posedge clk) begin
            for (int j = 0; j < (TOUT >> k); j++)
               sum[j] <= {lvl[k-1].sum[2*j][ELEM_W+k-2],   lvl[k-1].sum[2*j]}
                       + {lvl[k-1].sum[2*j+1][ELEM_W+k-2], lvl[k-1].sum[2*j+1]};
         end
      end
   end

   logic signed [ELEM_W+LOG2_TOUT-1:0] tree_out;
   assign tree_out = lvl[LOG2_TOUT].sum[0];

   // ---------------- SA: accumulate and packet tracking ----------------
   logic                    t_v, t_f, t_l;
   logic [0:0]              state;
   logic signed [ACC_W-1:0] acc, acc_n, tree_ext;
   logic [BEAT_W:0]         cnt, cnt_n;
   logic                    err_pkt, err_n, err_pend;
   logic                    at_max;

   assign t_v = pv[LOG2_TOUT];
   assign t_f = pf[LOG2_TOUT];
   assign t_l = pl[LOG2_TOUT];

   always_comb begin
      tree_ext = ACC_W'(tree_out);
      at_max   = (cnt == BEAT_MAX);
      acc_n    = t_f ? tree_ext : acc + tree_ext;
      cnt_n    = t_f ? BEAT_ONE : (at_max ? BEAT_MAX : cnt + BEAT_ONE);
      // A first flag seen while in ACC means the previous packet had no
      // last beat. A beat that arrives after the count has saturated
      // means the packet overflowed.
      err_n    = t_f ? (state == ST_ACC) : (err_pkt | at_max);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         acc      <= '0;
         cnt      <= '0;
         err_pkt  <= 1'b0;
         err_pend <= 1'b0;
         o_valid  <= 1'b0;
         o_dat    <= '0;
         o_beats  <= '0;
         o_err    <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (t_v) begin
            if (state == ST_IDLE && !t_f) begin
               // A beat outside any packet is dropped. The next result
               // carries the error flag.
               err_pend <= 1'b1;
            end else begin
               acc     <= acc_n;
               cnt     <= cnt_n;
               err_pkt <= err_n;
               if (t_l) begin
                  o_valid  <= 1'b1;
                  o_dat    <= acc_n;
                  o_beats  <= cnt_n;
                  o_err    <= err_n | err_pend;
                  err_pend <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  state    <= ST_ACC;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tout_acc_stream.sv
// tb_tout_acc_stream
//   Self-checking bench for tout_acc_stream at default parameters.
//   Directed beats are driven on the falling edge. Each beat also feeds a
//   packet-level model. When the model closes a packet, it queues the
//   expected result, stamped with the cycle in which o_valid must appear.
//   A compare process checks the outputs on every falling edge. Literal
//   checks after selected packets pin the model to hand-computed values.
module tb_tout_acc_stream;

   localparam int DW    = 16;
   localparam int T     = 32;
   localparam int L     = 5;
   localparam int BW    = 8;
   localparam int ACC_W = 2*DW + L + BW;
   localparam int VW    = DW*T;
   localparam int EXP_W = 32 + 1 + (BW+1) + ACC_W;
   localparam int BMAX  = 1 << BW;

   logic                    clk, rst;
   logic                    i_valid, i_first, i_last, i_sq;
   logic [VW-1:0]           i_dat;
   logic                    o_valid;
   logic signed [ACC_W-1:0] o_dat;
   logic [BW:0]             o_beats;
   logic                    o_err;

   tout_acc_stream #(
      .DATA_WIDTH(DW), .TOUT(T), .LOG2_TOUT(L), .BEAT_W(BW)
   ) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_first(i_first), .i_last(i_last), .i_sq(i_sq),
      .i_dat(i_dat),
      .o_valid(o_valid), .o_dat(o_dat), .o_beats(o_beats), .o_err(o_err)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;
   logic [EXP_W-1:0] exp_q[$];

   logic signed [ACC_W-1:0] last_dat   = '0;
   logic [BW:0]             last_beats = '0;
   logic                    last_err   = 1'b0;

   // Packet-level model state
   bit     m_in   = 0;
   bit     m_mode = 0;
   bit     m_err  = 0;
   bit     m_pend = 0;
   longint m_acc  = 0;
   int     m_beats = 0;

   function automatic logic [VW-1:0] fill(input int v);
      logic [VW-1:0] d;
      for (int k = 0; k < T; k++) d[k*DW +: DW] = DW'(v);
      return d;
   endfunction

   function automatic logic [VW-1:0] ramp();
      logic [VW-1:0] d;
      for (int k = 0; k < T; k++) d[k*DW +: DW] = DW'(k - 16);
      return d;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic beat(input bit f, input bit l, input bit sq, input logic [VW-1:0] d);
      longint bs;
      longint x;
      logic [ACC_W-1:0] ab;
      logic [BW:0]      bb;
      logic [31:0]      st;
      @(negedge clk);
      i_valid = 1'b1;
      i_first = f;
      i_last  = l;
      i_sq    = sq;
      i_dat   = d;
      if (f) m_mode = sq;
      bs = 0;
      for (int k = 0; k < T; k++) begin
         x  = longint'($signed(d[k*DW +: DW]));
         bs = bs + (m_mode ? x * x : x);
      end
      if (!m_in && !f) begin
         m_pend = 1;
      end else begin
         if (f) begin
            m_err   = m_in;
            m_acc   = bs;
            m_beats = 1;
         end else begin
            if (m_beats == BMAX) m_err = 1;
            else                 m_beats = m_beats + 1;
            m_acc = m_acc + bs;
         end
         if (l) begin
            ab = m_acc[ACC_W-1:0];
            bb = m_beats[BW:0];
            st = cyc + 8;
            exp_q.push_back({st, m_err | m_pend, bb, ab});
            m_pend = 0;
            m_in   = 0;
         end else begin
            m_in = 1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         i_valid = 1'b0;
         i_first = 1'b0;
         i_last  = 1'b0;
      end
   endtask

   task automatic drain();
      idle(1);
      for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expected results never appeared (required 0 pending)", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      i_valid = 1'b0;
      i_first = 1'b0;
      i_last  = 1'b0;
      m_in = 0; m_mode = 0; m_err = 0; m_pend = 0; m_acc = 0; m_beats = 0;
      exp_q.delete();
      last_dat = '0; last_beats = '0; last_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if (o_valid !== 1'b0 || o_dat !== '0 || o_beats !== '0 || o_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: valid=%0b dat=%0d beats=%0d err=%0b, required all 0",
                  o_valid, o_dat, o_beats, o_err);
      end
   endtask

   task automatic check_last(input string name, input longint dat, input int beats, input bit err);
      tests++;
      if (longint'(last_dat) != dat || int'(last_beats) != beats || last_err != err) begin
         fails++;
         $display("FAIL %s: got dat=%0d beats=%0d err=%0b, required dat=%0d beats=%0d err=%0b",
                  name, last_dat, last_beats, last_err, dat, beats, err);
      end
   endtask

   // ---------------- compare process ----------------
   initial begin
      logic [EXP_W-1:0] h;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            while (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) < cyc) begin
               h = exp_q.pop_front();
               tests++;
               fails++;
               $display("FAIL missing_valid: no o_valid at cycle %0d, required dat=%0d",
                        int'(h[EXP_W-1 -: 32]), $signed(h[ACC_W-1:0]));
            end
            if (o_valid === 1'b1) begin
               tests++;
               if (exp_q.size() == 0 || int'(exp_q[0][EXP_W-1 -: 32]) != cyc) begin
                  fails++;
                  $display("FAIL unexpected_valid: o_valid at cycle %0d dat=%0d, required no pulse",
                           cyc, o_dat);
               end else begin
                  h = exp_q.pop_front();
                  if (o_dat !== h[ACC_W-1:0] || o_beats !== h[ACC_W +: BW+1] ||
                      o_err !== h[ACC_W+BW+1]) begin
                     fails++;
                     $display("FAIL result: got dat=%0d beats=%0d err=%0b, required dat=%0d beats=%0d err=%0b",
                              o_dat, o_beats, o_err, $signed(h[ACC_W-1:0]),
                              h[ACC_W +: BW+1], h[ACC_W+BW+1]);
                  end
               end
               last_dat   = o_dat;
               last_beats = o_beats;
               last_err   = o_err;
            end else begin
               tests++;
               if (o_valid !== 1'b0 || o_dat !== last_dat || o_beats !== last_beats ||
                   o_err !== last_err) begin
                  fails++;
                  $display("FAIL hold: valid=%0b dat=%0d beats=%0d err=%0b, required 0/%0d/%0d/%0b",
                           o_valid, o_dat, o_beats, o_err, last_dat, last_beats, last_err);
               end
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; i_sq = 1'b0;
      i_dat = '0;
      repeat (2) @(negedge clk);
      do_reset();

      // single beat, all lanes 1
      beat(1, 1, 0, fill(1));
      drain();
      check_last("single_ones", 32, 1, 0);

      // most negative lanes, sum then square
      beat(1, 1, 0, fill(-32768));
      drain();
      check_last("neg_sum", -1048576, 1, 0);
      beat(1, 1, 1, fill(-32768));
      drain();
      check_last("neg_sq", 64'sd34359738368, 1, 0);

      // distinct lanes k-16 exercise every tree input
      beat(1, 1, 0, ramp());
      drain();
      check_last("ramp_sum", -16, 1, 0);
      beat(1, 1, 1, ramp());
      drain();
      check_last("ramp_sq", 2736, 1, 0);

      // 4-beat squared packet, i_sq only on first beat, gap between beats 2 and 3
      beat(1, 0, 1, fill(1));
      beat(0, 0, 0, fill(2));
      idle(2);
      beat(0, 0, 0, fill(3));
      beat(0, 1, 0, fill(4));
      drain();
      check_last("sq4_gap", 960, 4, 0);

      // back-to-back packets
      beat(1, 1, 0, fill(-1));
      beat(1, 0, 0, fill(5));
      beat(0, 1, 0, fill(5));
      drain();
      check_last("b2b_p2", 320, 2, 0);

      // missing last: restart on new first
      beat(1, 0, 0, fill(2));
      beat(0, 0, 0, fill(2));
      beat(1, 1, 0, fill(2));
      drain();
      check_last("restart", 64, 1, 1);

      // lone beat without first, then a packet reports the error
      beat(0, 1, 0, fill(9));
      idle(2);
      beat(1, 1, 0, fill(1));
      drain();
      check_last("lone_beat", 32, 1, 1);
      beat(1, 1, 0, fill(1));
      drain();
      check_last("err_cleared", 32, 1, 0);

      // reset with three beats in flight
      beat(1, 0, 0, fill(7));
      beat(0, 0, 0, fill(7));
      beat(0, 1, 0, fill(7));
      do_reset();
      idle(12);
      beat(1, 1, 0, fill(3));
      drain();
      check_last("after_reset", 96, 1, 0);

      // exactly 2^BEAT_W beats, squared mode
      for (int i = 0; i < BMAX; i++) beat(i == 0, i == BMAX-1, 1, fill(1));
      drain();
      check_last("beats_max", 8192, 256, 0);

      // one beat beyond the limit
      for (int i = 0; i <= BMAX; i++) beat(i == 0, i == BMAX, 0, fill(1));
      drain();
      check_last("beats_ovf", 8224, 256, 1);

      idle(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
